// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART register-write link: frame parser states
// and the frame start marker.
package uart_link_pkg;

    // Frame parser phases, in the order bytes arrive, plus the write burst
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CHK,
        COMMIT
    } link_state_t;

    // Marker byte that opens every frame
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl.sv
// Turns a stream of received UART bytes into register writes.
// Frames are SYNC, ADDR, LEN, DATA[LEN], CHK. The payload is held back until
// the XOR checksum passes, then replayed as a burst of consecutive writes.
// Aborted frames (bad length, bad checksum, inter-byte timeout) pulse
// frame_err and bump a saturating error counter.
module uart_frame_ctrl
    import uart_link_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [7:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            err_cnt
);

    localparam int IDX_W = $clog2(MAX_LEN) + 1;
    localparam int GAP_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    link_state_t state;
    link_state_t next_state;

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      len;
    logic [GAP_W-1:0]      gap;
    logic [7:0]            addr;
    logic [DATA_WIDTH-1:0] chk;
    logic [DATA_WIDTH-1:0] buffer [MAX_LEN];

    logic                  accept;
    logic                  in_frame;
    logic                  gap_expired;
    logic                  len_bad;
    logic                  at_last;
    logic                  abort;
    logic [SEL_W-1:0]      sel;

    // State register; the parser only moves on enabled cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    // Next-state decode plus the handshake, write burst and error strobes
    always_comb begin
        next_state  = state;
        rx_ready    = ~reset_n | (ena & (state != COMMIT));
        accept      = ena & rx_valid & rx_ready;
        in_frame    = (state == ADDR) || (state == LEN) ||
                      (state == DATA) || (state == CHK);
        gap_expired = ena && in_frame && !accept &&
                      (gap == GAP_W'(TIMEOUT_CYCLES - 1));
        len_bad     = (rx_data == '0) || (rx_data > DATA_WIDTH'(MAX_LEN));
        at_last     = (idx == len - IDX_W'(1));
        sel         = idx[SEL_W-1:0];
        abort       = gap_expired;
        wr_en       = 1'b0;
        wr_addr     = 8'h00;
        wr_data     = '0;
        frame_ok    = 1'b0;
        frame_err   = 1'b0;

        case (state)
            IDLE: begin
                if (accept && (rx_data == DATA_WIDTH'(SYNC_BYTE))) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (accept) begin
                    next_state = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        abort = 1'b1;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && at_last) begin
                    next_state = CHK;
                end
            end
            CHK: begin
                if (accept) begin
                    if ((chk ^ rx_data) == '0) begin
                        next_state = COMMIT;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (ena) begin
                    wr_en   = 1'b1;
                    wr_addr = addr + 8'(idx);
                    wr_data = buffer[sel];
                    if (at_last) begin
                        frame_ok   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (abort) begin
            next_state = IDLE;
            frame_err  = 1'b1;
        end
    end

    // Frame datapath: header capture, payload buffer, running checksum,
    // byte index, inter-byte gap timer and the error counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            len     <= '0;
            gap     <= '0;
            addr    <= 8'h00;
            chk     <= '0;
            err_cnt <= 8'h00;
            for (int i = 0; i < MAX_LEN; i++) begin
                buffer[i] <= '0;
            end
        end else if (ena) begin
            if (abort && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (abort || accept || !in_frame) begin
                gap <= '0;
            end else begin
                gap <= gap + GAP_W'(1);
            end

            case (state)
                IDLE: begin
                    idx <= '0;
                end
                ADDR: begin
                    if (accept) begin
                        addr <= rx_data[7:0];
                        chk  <= rx_data;
                    end
                end
                LEN: begin
                    if (accept) begin
                        len <= IDX_W'(rx_data);
                        chk <= chk ^ rx_data;
                        idx <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        buffer[sel] <= rx_data;
                        chk         <= chk ^ rx_data;
                        idx         <= at_last ? '0 : idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    idx <= at_last ? '0 : idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl. A byte-queue frame model predicts
// every output each cycle; directed frames pin the model with literal values.
module tb_uart_frame_ctrl;

    localparam int DW = 8;
    localparam int ML = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ena;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_ok;
    logic          frame_err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;
    bit useRandEna = 1'b0;

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [7:0] addr; logic [7:0] data; logic ok; } log_t;

    bit         m_in_frame = 1'b0;
    logic [7:0] m_bytes[$];
    int         m_gap = 0;
    wr_t        m_writes[$];
    int         m_err = 0;

    log_t wr_log[$];
    int   err_pulses   = 0;
    int   since_accept = 0;
    int   err_gap      = -1;

    logic [7:0] frm[$];

    uart_frame_ctrl #(
        .DATA_WIDTH(DW),
        .MAX_LEN(ML),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ena(ena),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkLog(input string name, input int idx, input logic [7:0] a,
                            input logic [7:0] d, input logic ok);
        if (idx < wr_log.size()) begin
            checkOutput({name, "_addr"}, wr_log[idx].addr, a);
            checkOutput({name, "_data"}, wr_log[idx].data, d);
            checkOutput({name, "_ok"}, wr_log[idx].ok, ok);
        end else begin
            checkOutput({name, "_present"}, wr_log.size(), idx + 1);
        end
    endtask

    function automatic logic randEna();
        return useRandEna ? ($urandom_range(0, 7) != 0) : 1'b1;
    endfunction

    // Predict every output from the frame rules, compare, then advance the model
    always @(negedge clk) begin : compare
        logic       e_ready, e_wr, e_ok, e_err;
        logic [7:0] e_addr, e_data, e_cnt, x;
        bit         abort_now;

        e_ready = 1'b0; e_wr = 1'b0; e_ok = 1'b0; e_err = 1'b0;
        e_addr = 8'h00; e_data = 8'h00; abort_now = 1'b0;

        if (!reset_n) begin
            e_ready = 1'b1;
            e_cnt   = 8'h00;
            m_in_frame = 1'b0; m_bytes.delete(); m_gap = 0;
            m_writes.delete(); m_err = 0;
        end else begin
            e_cnt = 8'(m_err);
            if (!ena) begin
                e_ready = 1'b0;
            end else if (m_writes.size() > 0) begin
                e_wr   = 1'b1;
                e_addr = m_writes[0].addr;
                e_data = m_writes[0].data;
                e_ok   = (m_writes.size() == 1);
                void'(m_writes.pop_front());
            end else begin
                e_ready = 1'b1;
                if (!m_in_frame) begin
                    if (rx_valid && rx_data == 8'hA5) begin
                        m_in_frame = 1'b1; m_bytes.delete(); m_gap = 0;
                    end
                end else if (rx_valid) begin
                    m_bytes.push_back(rx_data);
                    m_gap = 0;
                    if (m_bytes.size() == 2 && (rx_data == 0 || int'(rx_data) > ML)) begin
                        abort_now = 1'b1;
                    end else if (m_bytes.size() > 2 && m_bytes.size() == int'(m_bytes[1]) + 3) begin
                        x = 8'h00;
                        foreach (m_bytes[i]) x ^= m_bytes[i];
                        if (x == 8'h00) begin
                            for (int i = 0; i < int'(m_bytes[1]); i++)
                                m_writes.push_back('{addr: 8'(int'(m_bytes[0]) + i), data: m_bytes[2 + i]});
                            m_in_frame = 1'b0;
                        end else begin
                            abort_now = 1'b1;
                        end
                    end
                end else begin
                    m_gap++;
                    if (m_gap >= TO) abort_now = 1'b1;
                end
                if (abort_now) begin
                    e_err = 1'b1;
                    m_in_frame = 1'b0;
                    if (m_err < 255) m_err++;
                end
            end
        end

        checkOutput("rx_ready", rx_ready, e_ready);
        checkOutput("wr_en", wr_en, e_wr);
        checkOutput("wr_addr", wr_addr, e_addr);
        checkOutput("wr_data", wr_data, e_data);
        checkOutput("frame_ok", frame_ok, e_ok);
        checkOutput("frame_err", frame_err, e_err);
        checkOutput("err_cnt", err_cnt, e_cnt);

        if (wr_en === 1'b1) wr_log.push_back('{addr: wr_addr, data: wr_data, ok: frame_ok});
        if (reset_n && ena && rx_valid && rx_ready) since_accept = 0;
        else if (reset_n && ena) since_accept++;
        if (frame_err === 1'b1) begin
            err_pulses++;
            err_gap = since_accept;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            ena      = randEna();
            @(posedge clk); #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, output int waited);
        bit done = 1'b0;
        waited = 0;
        while (!done) begin
            rx_valid = 1'b1;
            rx_data  = b;
            ena      = randEna();
            @(negedge clk);
            done = ena && rx_ready;
            @(posedge clk); #1;
            waited++;
            if (!done && waited > 300) begin
                total++; bad++;
                $display("[TB] FAIL byte_accept: waited %0d cycles, required under 300", waited);
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] bytes[$], input int maxGap);
        int w;
        foreach (bytes[i]) begin
            if (maxGap > 0) idle($urandom_range(0, maxGap));
            sendByte(bytes[i], w);
        end
    endtask

    task automatic randomFrame();
        logic [7:0] f[$];
        logic [7:0] x, a;
        int kind = $urandom_range(0, 9);
        int n = $urandom_range(1, ML);
        a = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
        if (kind == 8) begin
            for (int i = 0; i < $urandom_range(1, 3); i++) begin
                x = 8'($urandom);
                if (x == 8'hA5) x = 8'h00;
                f.push_back(x);
            end
        end
        f.push_back(8'hA5);
        f.push_back(a);
        if (kind == 7) begin
            x = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255));
            f.push_back(x);
        end else begin
            f.push_back(8'(n));
            x = a ^ 8'(n);
            for (int i = 0; i < n; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
                f.push_back(a);
                x ^= a;
            end
            if (kind == 6) x ^= 8'(1 << $urandom_range(0, 7));
            f.push_back(x);
        end
        if (kind == 9) begin
            f = f[0:$urandom_range(1, f.size() - 2)];
            applyStimulus(f, 3);
            idle(2 * TO + 20);
        end else begin
            applyStimulus(f, 3);
        end
    endtask

    // Watchdog against a stuck run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0, p0, w;
        reset_n = 1'b0; ena = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rx_ready", rx_ready, 1);
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        reset_n = 1'b1;
        idle(4);

        $display("[TB] good frame");
        wr_log.delete();
        frm = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        applyStimulus(frm, 2); idle(6);
        checkOutput("good_nwrites", wr_log.size(), 2);
        checkLog("good_w0", 0, 8'h10, 8'h33, 1'b0);
        checkLog("good_w1", 1, 8'h11, 8'h44, 1'b1);
        checkOutput("good_err_cnt", err_cnt, 0);
        checkOutput("good_err_pulses", err_pulses, 0);

        $display("[TB] address wrap");
        wr_log.delete();
        frm = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE};
        applyStimulus(frm, 2); idle(6);
        checkLog("wrap_w0", 0, 8'hFF, 8'h01, 1'b0);
        checkLog("wrap_w1", 1, 8'h00, 8'h02, 1'b1);

        $display("[TB] bad checksum");
        wr_log.delete(); p0 = err_pulses;
        frm = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
        applyStimulus(frm, 2); idle(6);
        checkOutput("badchk_nwrites", wr_log.size(), 0);
        checkOutput("badchk_pulses", err_pulses - p0, 1);
        checkOutput("badchk_err_cnt", err_cnt, 1);

        $display("[TB] noise and zero length");
        wr_log.delete(); p0 = err_pulses;
        frm = '{8'h00, 8'h7E, 8'hA5, 8'h10, 8'h00};
        applyStimulus(frm, 2); idle(6);
        checkOutput("badlen_nwrites", wr_log.size(), 0);
        checkOutput("badlen_pulses", err_pulses - p0, 1);
        checkOutput("badlen_err_cnt", err_cnt, 2);
        frm = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        applyStimulus(frm, 2); idle(6);
        checkOutput("after_badlen_nwrites", wr_log.size(), 2);

        $display("[TB] timeout");
        wr_log.delete(); p0 = err_pulses;
        frm = '{8'hA5, 8'h10};
        applyStimulus(frm, 2); idle(TO + 10);
        checkOutput("timeout_gap", err_gap, TO);
        checkOutput("timeout_pulses", err_pulses - p0, 1);
        checkOutput("timeout_err_cnt", err_cnt, 3);
        frm = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        applyStimulus(frm, 2); idle(6);
        checkLog("timeout_next_w0", 0, 8'h10, 8'h33, 1'b0);
        checkLog("timeout_next_w1", 1, 8'h11, 8'h44, 1'b1);

        $display("[TB] backpressure through commit");
        wr_log.delete();
        frm = '{8'hA5, 8'h40, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h4E};
        applyStimulus(frm, 0);
        sendByte(8'hA5, w);
        checkOutput("backpressure_wait", w, 4);
        frm = '{8'h30, 8'h01, 8'h77, 8'h46};
        applyStimulus(frm, 0); idle(4);
        checkOutput("backpressure_nwrites", wr_log.size(), 4);
        checkLog("backpressure_w3", 3, 8'h30, 8'h77, 1'b1);

        $display("[TB] random frames");
        useRandEna = 1'b1;
        for (int i = 0; i < 60; i++) randomFrame();
        idle(20);
        useRandEna = 1'b0;
        idle(6);

        $display("[TB] error counter saturation");
        frm = '{8'hA5, 8'h10, 8'h00};
        for (int i = 0; i < 260; i++) applyStimulus(frm, 0);
        idle(2);
        checkOutput("sat_err_cnt", err_cnt, 8'hFF);

        $display("[TB] reset during commit");
        wr_log.delete(); e0 = err_pulses;
        frm = '{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20};
        applyStimulus(frm, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_frame_ok", frame_ok, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_rx_ready", rx_ready, 1);
        idle(3);
        checkOutput("rst_nwrites", wr_log.size(), 1);
        checkOutput("rst_no_err_pulse", err_pulses - e0, 0);
        reset_n = 1'b1;
        idle(3);
        wr_log.delete();
        frm = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE};
        applyStimulus(frm, 1); idle(6);
        checkLog("post_rst_w0", 0, 8'hFF, 8'h01, 1'b0);
        checkLog("post_rst_w1", 1, 8'h00, 8'h02, 1'b1);
        checkOutput("post_rst_err_cnt", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width consumed from the receiver.
REQ-002 SHALL have parameter MAX_LEN, default 4, the maximum payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000, the maximum inter-byte gap in ena cycles.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ena, input, 1, global enable; all state advances only when high.
REQ-007 SHALL have port rx_data, input, DATA_WIDTH, the byte from the receiver.
REQ-008 SHALL have port rx_valid, input, 1, the receiver byte-available flag.
REQ-009 SHALL have port rx_ready, output, 1, the consume strobe returned to the receiver.
REQ-010 SHALL have port wr_en, output, 1, the register-write strobe.
REQ-011 SHALL have port wr_addr, output, 8, the register-write address.
REQ-012 SHALL have port wr_data, output, DATA_WIDTH, the register-write data.
REQ-013 SHALL have port frame_ok, output, 1, a one-cycle pulse on the last write of a good frame.
REQ-014 SHALL have port frame_err, output, 1, a one-cycle pulse on any aborted frame.
REQ-015 SHALL have port err_cnt, output, 8, a saturating count of aborted frames.

Function
REQ-016 Frame format SHALL be SYNC(0xA5), ADDR, LEN, DATA[0..LEN-1], CHK, where CHK = ADDR ^ LEN ^ all DATA bytes.
REQ-017 A byte SHALL be accepted when ena && rx_valid && rx_ready.
REQ-018 rx_ready SHALL be combinational: high in IDLE, ADDR, LEN, DATA and CHK; low in COMMIT.
REQ-019 FSM transitions SHALL be:
- IDLE: SYNC -> ADDR; any other byte is discarded silently, with no error.
- ADDR -> LEN, always.
- LEN: 1..MAX_LEN -> DATA; 0 or >MAX_LEN -> abort.
- DATA: after LEN bytes -> CHK.
- CHK: match -> COMMIT; mismatch -> abort.
REQ-020 DATA bytes SHALL be buffered in a MAX_LEN x DATA_WIDTH register array; no write SHALL occur before the checksum passes.
REQ-021 COMMIT SHALL issue exactly LEN wr_en pulses on consecutive ena cycles:
- timing: the first pulse is on the cycle after CHK is accepted;
- addressing: wr_addr = ADDR + i mod 256, so writes wrap 0xFF -> 0x00;
- data: wr_data = DATA[i].
REQ-022 frame_ok SHALL coincide with the final wr_en; the FSM SHALL return to IDLE on the next cycle.
REQ-023 Timeout: in ADDR, LEN, DATA or CHK, TIMEOUT_CYCLES ena cycles without an accepted byte SHALL abort; the gap counter SHALL reset on every accepted byte.
REQ-024 Abort SHALL pulse frame_err for one cycle, increment err_cnt (saturating at 0xFF), and return to IDLE with no writes.
REQ-025 A SYNC byte received mid-frame SHALL be treated as ordinary data; there is no resynchronisation except via timeout or error.
REQ-026 When ena is low, all registers SHALL hold, rx_ready SHALL be forced low, and wr_en, frame_ok and frame_err SHALL be low.

Reset
REQ-027 Asserting reset_n low SHALL immediately set the following, including mid-frame and mid-COMMIT (partial burst abandoned, not counted as an error):
- state = IDLE;
- wr_en, frame_ok, frame_err = 0;
- wr_addr, wr_data, err_cnt = 0;
- buffer, gap counter, byte index = 0.
REQ-028 rx_ready SHALL read 1 during reset.

Structure
REQ-029 Package uart_link_pkg SHALL hold the state enum (IDLE, ADDR, LEN, DATA, CHK, COMMIT) and the constant SYNC_BYTE = 8'hA5.
REQ-030 The block SHALL be a single module with no sub-modules; the parent instantiates uart_rx and wires rx_data, rx_valid and rx_ready directly.
REQ-031 The byte index SHALL be $clog2(MAX_LEN)+1 bits wide; the gap counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits wide.

Verification
REQ-032 Good frame: A5,10,02,33,44,65 -> wr 0x33@0x10 then 0x44@0x11 on consecutive cycles; frame_ok on the second write; err_cnt = 0.
REQ-033 Address wrap: A5,FF,02,01,02,FE -> wr 0x01@0xFF then 0x02@0x00; frame_ok asserted.
REQ-034 Bad checksum: A5,10,02,33,44,66 -> no wr_en; frame_err pulses once; err_cnt = 1.
REQ-035 Bad length and noise: bytes 00,7E then A5,10,00 -> noise bytes ignored; LEN = 0 aborts; err_cnt increments by 1; the next good frame is accepted.
REQ-036 Timeout: A5,10 then silence for TIMEOUT_CYCLES (set to 100) -> frame_err at gap cycle 100; state IDLE; a following good frame writes correctly.
REQ-037 Backpressure and reset: rx_valid held high through COMMIT -> rx_ready low until IDLE; reset_n low during COMMIT -> writes stop immediately and all outputs are 0.
